// File: rtl/clk_tick_gen_if.sv
// clk_tick_gen_if: groups the tick generator's control inputs and tick/reset outputs.
//   enable  : high = tick counters advance
//   div_in  : packed per-channel divisors, channel k at [k*DIV_W +: DIV_W]
//   rst_out : synchronous active-high reset for downstream logic
//   tick    : one-cycle enable pulse per channel
//   phase   : 50% square wave per channel, toggles on each tick
//   running : high while the generator is in its run state
// Modports: master drives enable/div_in (system side), slave is the generator.
interface clk_tick_gen_if #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned DIV_W = 27
);
    logic                   enable;
    logic [NCH*DIV_W-1:0]   div_in;
    logic                   rst_out;
    logic [NCH-1:0]         tick;
    logic [NCH-1:0]         phase;
    logic                   running;

    modport master (
        output enable,
        output div_in,
        input  rst_out,
        input  tick,
        input  phase,
        input  running
    );

    modport slave (
        input  enable,
        input  div_in,
        output rst_out,
        output tick,
        output phase,
        output running
    );
endinterface

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: reset conditioner plus NCH programmable clock-enable tick channels.
//   clk   : system clock, all logic on its rising edge
//   reset : asynchronous active-low reset
//   bus   : clk_tick_gen_if slave (enable, div_in in; rst_out, tick, phase, running out)
// Reset release is double-synchronised, then rst_out is held for RST_STRETCH more cycles
// before the run state is entered. Each channel counts enabled run cycles against a
// shadow divisor that reloads only at terminal count, so periods are never cut short.
// Divisors 0 and 1 both produce a tick on every advancing cycle.
// Optional build macro TICKGEN_CASCADE_EN: channel k>0 advances only when channel k-1
// reaches terminal count, so its period is the product of the divisors up to k.
module clk_tick_gen #(
    parameter int unsigned NCH         = 3,
    parameter int unsigned DIV_W       = 27,
    parameter int unsigned RST_STRETCH = 16
) (
    input  logic          clk,
    input  logic          reset,
    clk_tick_gen_if.slave bus
);
    localparam int unsigned SW = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
    localparam logic [SW-1:0] StretchLast = SW'(RST_STRETCH - 1);

    typedef enum logic [1:0] {StReset, StStretch, StRun} state_e;

    state_e        state_q, state_d;
    logic [1:0]    sync_q;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          run_d;
    logic          rst_out_q;
    logic          running_q;

    // Release synchroniser; assertion stays asynchronous through the flop reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StReset;
            scnt_q    <= '0;
            rst_out_q <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            rst_out_q <= !run_d;
            running_q <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            StReset: begin
                if (sync_q[1]) begin
                    state_d = StStretch;
                    scnt_d  = '0;
                end
            end
            StStretch: begin
                if (scnt_q == StretchLast) begin
                    state_d = StRun;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StReset;
        endcase
    end

    // Counters also advance on the edge that enters RUN, so a divisor-D channel ticks
    // in the D-th run cycle with a registered tick.
    assign run_d       = (state_d == StRun);
    assign bus.rst_out = rst_out_q;
    assign bus.running = running_q;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DIV_W-1:0] div_in_k;
        logic [DIV_W-1:0] cur_div;
        logic [DIV_W-1:0] lim;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] sdiv_q, sdiv_d;
        logic             adv;
        logic             term;
        logic             fire;
        logic             tick_q;
        logic             phase_q;

        assign div_in_k = bus.div_in[k*DIV_W +: DIV_W];

        // The shadow only becomes authoritative once running; before that it tracks
        // div_in, so compare against div_in directly on the run-entry edge.
        assign cur_div = (state_q == StRun) ? sdiv_q : div_in_k;
        assign lim     = (cur_div <= DIV_W'(1)) ? '0 : cur_div - DIV_W'(1);
        assign term    = (cnt_q == lim);

        if (k == 0) begin : g_src
            assign adv = run_d & bus.enable;
        end else begin : g_src
`ifdef TICKGEN_CASCADE_EN
            assign adv = run_d & bus.enable & g_ch[k-1].fire;
`else
            assign adv = run_d & bus.enable;
`endif
        end

        assign fire = adv & term;

        always_comb begin
            cnt_d  = cnt_q;
            sdiv_d = sdiv_q;
            if (adv) begin
                cnt_d = term ? '0 : cnt_q + DIV_W'(1);
            end
            if ((state_q == StStretch) || fire) begin
                sdiv_d = div_in_k;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q   <= '0;
                sdiv_q  <= '0;
                tick_q  <= 1'b0;
                phase_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                sdiv_q  <= sdiv_d;
                tick_q  <= fire;
                phase_q <= phase_q ^ fire;
            end
        end

        assign bus.tick[k]  = tick_q;
        assign bus.phase[k] = phase_q;
    end
endmodule

// File: tb/tb_clk_tick_gen.sv
module tb_clk_tick_gen;
    localparam int unsigned NCH         = 3;
    localparam int unsigned DIV_W       = 27;
    localparam int unsigned RST_STRETCH = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    clk_tick_gen_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

    clk_tick_gen #(
        .NCH        (NCH),
        .DIV_W      (DIV_W),
        .RST_STRETCH(RST_STRETCH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_div(input int d0, input int d1, input int d2);
        bus.div_in = {DIV_W'(d2), DIV_W'(d1), DIV_W'(d0)};
    endtask

    // Called at the negedge where reset was just released; the first rising edge after
    // release is E0, so rst_out must fall on E2+RST_STRETCH, the 19th edge.
    task automatic check_exit_seq(input string tag);
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            check({tag, "_rst_out"}, bus.rst_out, (i < 19));
            check({tag, "_running"}, bus.running, (i >= 19));
        end
    endtask

    // Leaves the bench at the negedge inside run cycle 1.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (19) @(negedge clk);
        check({tag, "_running"}, bus.running, 1);
    endtask

    initial begin
        logic [2:0] et;
        logic [2:0] ep;
        logic       t0;
        logic       p0;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        bus.enable = 1'b1;
        set_div(4, 1, 0);

        // Reset state and exit sequence.
        repeat (5) @(negedge clk);
        check("rst_rst_out", bus.rst_out, 1);
        check("rst_running", bus.running, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_phase", bus.phase, 0);
        reset = 1'b1;
        check_exit_seq("exit1");

        // Divisors {4,1,0}: run cycle c.
        for (int c = 1; c <= 21; c++) begin
            if (c > 1) @(negedge clk);
            t0 = (c % 4 == 0);
            p0 = (((c / 4) % 2) == 1);
`ifdef TICKGEN_CASCADE_EN
            et = {t0, t0, t0};
            ep = {p0, p0, p0};
`else
            et = {1'b1, 1'b1, t0};
            ep = {(c % 2 == 1), (c % 2 == 1), p0};
`endif
            if (c <= 16) begin
                check($sformatf("div410_tick_c%0d", c), bus.tick, et);
                check($sformatf("div410_phase_c%0d", c), bus.phase, ep);
            end
        end

        // Asynchronous reset pulse mid-period (cycle 21: all phases high).
        check("pre_rst_phase", bus.phase, 3'b111);
        #2 reset = 1'b0;
        #1;
        check("async_rst_out", bus.rst_out, 1);
        check("async_running", bus.running, 0);
        check("async_tick", bus.tick, 0);
        check("async_phase", bus.phase, 0);
        @(negedge clk);
        reset = 1'b1;
        check_exit_seq("exit2");

        // Divisor 10 changed to 3 at count 2: ticks at 10, then every 3.
        set_div(10, 1, 1);
        do_reset("chg");
        for (int c = 1; c <= 19; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("chg_tick0_c%0d", c), bus.tick[0],
                  (c == 10 || c == 13 || c == 16 || c == 19));
            if (c == 2) set_div(3, 1, 1);
        end

        // Enable low for 7 edges at count 5 of D=10.
        set_div(10, 1, 1);
        do_reset("en");
        for (int c = 1; c <= 27; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("en_tick0_c%0d", c), bus.tick[0], (c == 17 || c == 27));
            check($sformatf("en_phase0_c%0d", c), bus.phase[0], (c >= 17 && c < 27));
`ifndef TICKGEN_CASCADE_EN
            check($sformatf("en_tick1_c%0d", c), bus.tick[1], !(c >= 6 && c <= 12));
`endif
            if (c == 5) bus.enable = 1'b0;
            if (c == 12) bus.enable = 1'b1;
        end

        // Divisors {4,5}: independent or cascaded.
        set_div(4, 5, 1);
        do_reset("casc");
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
`ifdef TICKGEN_CASCADE_EN
            check($sformatf("casc_tick_c%0d", c), bus.tick[1:0],
                  {(c % 20 == 0), (c % 4 == 0)});
`else
            check($sformatf("indep_tick_c%0d", c), bus.tick[1:0],
                  {(c % 5 == 0), (c % 4 == 0)});
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
